// File: rtl/space_params.sv
// Screen geometry, ship placement and FSM encoding shared by the ship, alien and laser blocks.
package space_params;

  localparam logic [9:0] SCREEN_W     = 10'd640;
  localparam logic [9:0] SCREEN_H     = 10'd480;
  localparam logic [9:0] SHIP_TOP_ROW = 10'd440;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLYING = 2'd1;
  localparam logic [1:0] ST_COOL   = 2'd2;

  // Keeps a sprite of width w fully on screen when placed at column x.
  function automatic logic [9:0] clamp_col(input logic [9:0] x, input logic [9:0] w);
    logic [9:0] lim;
    lim = SCREEN_W - w;
    if (x > lim) begin
      return lim;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-bit rising-edge detector; the history flop loads RESET_VAL so a level
// already high when reset releases does not produce a pulse.
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev_d;
  logic prev_q;

  // Next value of the history flop.
  always_comb begin
    prev_d = d;
  end

  // History register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/laser.sv
// Player laser: launches from the gun on a fire press, climbs SPEED rows per
// frame, and enforces a cooldown after it leaves the top or hits an alien.
module laser
  import space_params::*;
#(
  parameter int SHIP_TOP = 440,
  parameter int LASER_H  = 8,
  parameter int LASER_W  = 2,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [9:0] gunPosition,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic       hit,
  output logic [9:0] laserX,
  output logic [9:0] laserY,
  output logic       active,
  output logic [2:0] color
);

  localparam int         CNT_W     = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [9:0] SPEED_V   = 10'(SPEED);
  localparam logic [9:0] START_Y   = 10'(SHIP_TOP - LASER_H);

  logic             fire_rise;
  logic             frame_tick;
  logic             frame_cond;

  logic [1:0]       state_d, state_q;
  logic [9:0]       laser_x_d, laser_x_q;
  logic [9:0]       laser_y_d, laser_y_q;
  logic [CNT_W-1:0] cool_cnt_d, cool_cnt_q;
  logic [2:0]       color_d, color_q;

  assign frame_cond = (hPos == 10'd0) && (vPos == SCREEN_H);

  edge_rise #(.RESET_VAL(1'b1)) u_fire_edge (
    .clk   (clk),
    .reset (reset),
    .d     (fire),
    .pulse (fire_rise)
  );

  edge_rise #(.RESET_VAL(1'b1)) u_frame_edge (
    .clk   (clk),
    .reset (reset),
    .d     (frame_cond),
    .pulse (frame_tick)
  );

  // Shot FSM: hit outranks the frame step; fire is only honoured in IDLE.
  always_comb begin
    state_d    = state_q;
    laser_x_d  = laser_x_q;
    laser_y_d  = laser_y_q;
    cool_cnt_d = cool_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_rise) begin
          state_d   = ST_FLYING;
          laser_x_d = clamp_col(gunPosition, 10'(LASER_W));
          laser_y_d = START_Y;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLYING: begin
        if (hit) begin
          state_d    = ST_COOL;
          cool_cnt_d = COOL_LOAD;
        end else if (frame_tick) begin
          if (laser_y_q >= SPEED_V) begin
            laser_y_d = laser_y_q - SPEED_V;
          end else begin
            state_d    = ST_COOL;
            cool_cnt_d = COOL_LOAD;
          end
        end else begin
          state_d = ST_FLYING;
        end
      end
      ST_COOL: begin
        if (frame_tick) begin
          if (cool_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cool_cnt_d = cool_cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_COOL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pixel hit test against the current sprite box, widened to avoid overflow at the right edge.
  always_comb begin
    if ((state_q == ST_FLYING) &&
        ({1'b0, hPos} >= {1'b0, laser_x_q}) &&
        ({1'b0, hPos} <  ({1'b0, laser_x_q} + 11'(LASER_W))) &&
        ({1'b0, vPos} >= {1'b0, laser_y_q}) &&
        ({1'b0, vPos} <  ({1'b0, laser_y_q} + 11'(LASER_H)))) begin
      color_d = 3'b111;
    end else begin
      color_d = 3'b000;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      laser_x_q  <= 10'd0;
      laser_y_q  <= 10'd0;
      cool_cnt_q <= '0;
      color_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      laser_x_q  <= laser_x_d;
      laser_y_q  <= laser_y_d;
      cool_cnt_q <= cool_cnt_d;
      color_q    <= color_d;
    end
  end

  assign laserX = laser_x_q;
  assign laserY = laser_y_q;
  assign active = (state_q == ST_FLYING);
  assign color  = color_q;

endmodule

// File: tb/tb_laser.sv
// Self-checking bench for laser: a frame-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_laser;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire;
  logic       hit;
  logic [9:0] gunPosition;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] laserX;
  logic [9:0] laserY;
  logic       active;
  logic [2:0] color;

  int errors = 0;
  int checks = 0;
  bit run_checks = 1'b0;

  // Reference model state: a shot is either in the air, cooling for some frames, or ready.
  bit m_fly;
  int m_cool_frames;
  int m_x, m_y, m_color;
  bit m_prev_cond, m_prev_fire;

  laser dut (
    .clk(clk), .reset(reset), .fire(fire), .gunPosition(gunPosition),
    .hPos(hPos), .vPos(vPos), .hit(hit), .laserX(laserX), .laserY(laserY),
    .active(active), .color(color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit cond, tick, rise;
    if (reset) begin
      m_fly = 1'b0; m_cool_frames = 0; m_x = 0; m_y = 0; m_color = 0;
      m_prev_cond = 1'b1; m_prev_fire = 1'b1;
    end else begin
      cond = (hPos == 10'd0) && (vPos == 10'd480);
      tick = cond && !m_prev_cond;
      m_prev_cond = cond;
      rise = fire && !m_prev_fire;
      m_prev_fire = fire;
      m_color = (m_fly && hPos >= m_x && hPos < m_x + 2 && vPos >= m_y && vPos < m_y + 8) ? 7 : 0;
      if (m_fly) begin
        if (hit || (tick && m_y < 4)) begin
          m_fly = 1'b0;
          m_cool_frames = 8;
        end else if (tick) begin
          m_y = m_y - 4;
        end
      end else if (m_cool_frames > 0) begin
        if (tick) m_cool_frames--;
      end else if (rise) begin
        m_fly = 1'b1;
        m_x = (gunPosition > 10'd638) ? 638 : int'(gunPosition);
        m_y = 432;
      end
    end
  end

  always @(negedge clk) begin
    if (run_checks) begin
      chk("model_active", int'(active), int'(m_fly));
      chk("model_laserX", int'(laserX), m_x);
      chk("model_laserY", int'(laserY), m_y);
      chk("model_color",  int'(color),  m_color);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Frame condition held for two clocks must yield a single tick.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      hPos = 10'd0; vPos = 10'd480;
      cyc(2);
      vPos = 10'd0;
      cyc(1);
    end
  endtask

  task automatic press();
    fire = 1'b1;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; fire = 1'b0; hit = 1'b0; gunPosition = 10'd0; hPos = 10'd0; vPos = 10'd0;
    cyc(2);
    run_checks = 1'b1;
    reset = 1'b0;
    cyc(1);
    chk("reset_active", int'(active), 0);
    chk("reset_x", int'(laserX), 0);
    chk("reset_y", int'(laserY), 0);
    chk("reset_color", int'(color), 0);

    // Launch and three frames of climb.
    gunPosition = 10'd300;
    press();
    chk("launch_active", int'(active), 1);
    chk("launch_x", int'(laserX), 300);
    chk("launch_y", int'(laserY), 432);
    fire = 1'b0;
    frames(3);
    chk("climb_y", int'(laserY), 420);

    // Hit together with a frame tick at row 200.
    frames(55);
    chk("pre_hit_y", int'(laserY), 200);
    hPos = 10'd0; vPos = 10'd480; hit = 1'b1;
    cyc(1);
    hit = 1'b0; vPos = 10'd0;
    chk("hit_active", int'(active), 0);
    chk("hit_y", int'(laserY), 200);
    press();
    fire = 1'b0;
    cyc(1);
    chk("cool_no_launch", int'(active), 0);
    frames(8);
    hit = 1'b1; cyc(1); hit = 1'b0;
    chk("idle_hit_ignored", int'(active), 0);

    // Clamp at the right edge; gun motion ignored in flight.
    gunPosition = 10'd639;
    press();
    chk("clamp_x", int'(laserX), 638);
    chk("clamp_active", int'(active), 1);
    fire = 1'b0;
    gunPosition = 10'd10;
    frames(1);
    chk("x_frozen", int'(laserX), 638);

    // Off the top, then the full cooldown.
    frames(106);
    chk("top_y4", int'(laserY), 4);
    frames(1);
    chk("top_y0", int'(laserY), 0);
    chk("top_still_active", int'(active), 1);
    frames(1);
    chk("top_cool_active", int'(active), 0);
    chk("top_cool_y", int'(laserY), 0);
    frames(7);
    press();
    chk("cool7_no_launch", int'(active), 0);
    fire = 1'b0;
    cyc(1);
    frames(1);
    press();
    chk("cool8_relaunch", int'(active), 1);
    chk("relaunch_x", int'(laserX), 10);

    // Reset mid-flight with fire held across release.
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_active", int'(active), 0);
    chk("rst_mid_y", int'(laserY), 0);
    reset = 1'b0;
    cyc(3);
    chk("held_fire_idle", int'(active), 0);
    fire = 1'b0;
    cyc(1);
    press();
    chk("after_held_launch", int'(active), 1);
    fire = 1'b0;

    // Pixel output at (100,300).
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    gunPosition = 10'd100;
    press();
    fire = 1'b0;
    frames(33);
    chk("pix_y", int'(laserY), 300);
    chk("pix_x", int'(laserX), 100);
    hPos = 10'd101; vPos = 10'd307;
    cyc(1);
    chk("pix_inside", int'(color), 7);
    hPos = 10'd102;
    cyc(1);
    chk("pix_outside", int'(color), 0);
    hPos = 10'd0; vPos = 10'd0;
    cyc(2);

    run_checks = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laser.md
LASER -- requirements
Module: laser

Interface
REQ-001 SHALL have parameter SHIP_TOP, default 440, meaning the first screen row of the ship sprite.
REQ-002 SHALL have parameter LASER_H, default 8, meaning the laser height in rows.
REQ-003 SHALL have parameter LASER_W, default 2, meaning the laser width in columns.
REQ-004 SHALL have parameter SPEED, default 4, meaning the rows moved per frame.
REQ-005 SHALL have parameter COOLDOWN, default 8, meaning the frames of dead time after the shot ends.
REQ-006 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port fire  input  1  level fire button; a shot is requested on a rising edge.
REQ-009 SHALL have port gunPosition  input  10  gun x-coordinate from the ship block.
REQ-010 SHALL have port hPos  input  10  current pixel column.
REQ-011 SHALL have port vPos  input  10  current pixel row.
REQ-012 SHALL have port hit  input  1  collision pulse from the alien block.
REQ-013 SHALL have port laserX  output  10  laser left column.
REQ-014 SHALL have port laserY  output  10  laser top row.
REQ-015 SHALL have port active  output  1  high while the laser is flying.
REQ-016 SHALL have port color  output  3  pixel color contribution.

Function
REQ-017 SHALL implement states IDLE, FLYING and COOL; active = (state==FLYING).
REQ-018 SHALL compute frameTick as a one-cycle pulse on the rising edge of (hPos==0 && vPos==480); a condition held for several clk cycles yields exactly one tick.
REQ-019 SHALL compute fireRise as fire & ~firePrev, where firePrev is the fire value registered one cycle earlier.
REQ-020 SHALL, in IDLE on fireRise, load laserX = min(gunPosition, 640-LASER_W) and laserY = SHIP_TOP-LASER_H (432), and enter FLYING on the next edge.
REQ-021 SHALL, in FLYING on frameTick, subtract SPEED from laserY if laserY >= SPEED; otherwise enter COOL and leave laserY unchanged (no wrap below 0).
REQ-022 SHALL, in FLYING when hit=1, enter COOL on the next edge; hit has priority over a simultaneous frameTick.
REQ-023 SHALL, on entry to COOL, load cooldownCnt = COOLDOWN-1; each frameTick decrements it; a frameTick at 0 returns to IDLE.
REQ-024 SHALL ignore fireRise in FLYING and COOL and SHALL NOT queue it.
REQ-025 SHALL ignore hit outside FLYING.
REQ-026 SHALL hold laserX and laserY at their last values in COOL and IDLE.
REQ-027 SHALL register color with 1-cycle latency: 3'b111 when active, laserX<=hPos<laserX+LASER_W and laserY<=vPos<laserY+LASER_H; else 3'b000.
REQ-028 SHALL ignore gunPosition changes during flight; laserX stays constant until the next launch.

Reset
REQ-029 SHALL, when reset=1 at a clk edge, set state=IDLE, laserX=0, laserY=0, color=0, cooldownCnt=0 and the frameTick edge register to 1.
REQ-030 SHALL load firePrev=1 on reset, so a button held through reset does not fire.
REQ-031 SHALL, on reset mid-flight or mid-cooldown, abort immediately with no residual shot.

Structure
REQ-032 SHALL place the screen constants (640, 480), SHIP_TOP and the state encoding in the shared space_params package used by the ship and alien blocks.
REQ-033 SHALL use one sub-module, edge_rise (1-bit rising-edge detector with reset-load value), instantiated for fire and for the frame condition.

Verification
REQ-034 SHALL test launch: gunPosition=300, fire 0->1 -> active=1, laserX=300, laserY=432; after 3 frameTicks laserY=420.
REQ-035 SHALL test clamping: gunPosition=639, fire rise -> laserX=638.
REQ-036 SHALL test off-top: laserY=4, frameTick -> laserY=0; next frameTick -> COOL, active=0; 8 frameTicks -> IDLE.
REQ-037 SHALL test hit priority: hit and frameTick in the same cycle at laserY=200 -> COOL, laserY=200; fire during COOL -> no launch.
REQ-038 SHALL test held fire and reset: fire held high across reset release -> stays IDLE; fire 0->1 -> launch; reset mid-flight -> active=0, laserY=0.
REQ-039 SHALL test pixel output: laser at (100,300), hPos=101, vPos=307 -> color=3'b111 one cycle later; hPos=102 -> 3'b000.
